// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - IF/ID pipeline register with load-use hazard detection and stall/flush counters
module if_id_stage #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  PC_RESET = 32'h0000_0000,
    parameter int               CNT_W    = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  instr_i,
    input  logic             if_valid_i,
    input  logic             flush_i,
    input  logic             idex_memread_i,
    input  logic [4:0]       idex_rd_i,
    output logic [XLEN-1:0]  pc_o,
    output logic [XLEN-1:0]  instr_o,
    output logic             valid_o,
    output logic             pc_write_o,
    output logic             stall_o,
    output logic             noop_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_used;
    logic       rs2_used;
    logic       hazard;
    logic       flush_accept;

    assign opcode = instr_o[6:0];
    assign rs1    = instr_o[19:15];
    assign rs2    = instr_o[24:20];

    always_comb begin
        rs1_used = 1'b0;
        rs2_used = 1'b0;
        case (opcode)
            OP_REG, OP_STORE, OP_BRANCH: begin
                rs1_used = 1'b1;
                rs2_used = 1'b1;
            end
            OP_IMM, OP_LOAD: rs1_used = 1'b1;
            default: begin
                rs1_used = 1'b0;
                rs2_used = 1'b0;
            end
        endcase
    end

    // x0 is never a real destination, so a load into it cannot create a dependency
    assign hazard = valid_o && idex_memread_i && (idex_rd_i != 5'd0) &&
                    ((rs1_used && (idex_rd_i == rs1)) || (rs2_used && (idex_rd_i == rs2)));

    assign stall_o      = hazard;
    assign noop_o       = hazard;
    assign pc_write_o   = ~hazard;
    assign flush_accept = flush_i && !hazard;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pc_o    <= PC_RESET;
            instr_o <= '0;
            valid_o <= 1'b0;
        end else if (hazard) begin
            // branch in ID has no operands yet; controller re-raises flush after the stall
            pc_o    <= pc_o;
            instr_o <= instr_o;
            valid_o <= valid_o;
        end else if (flush_i) begin
            pc_o    <= pc_i;
            instr_o <= '0;
            valid_o <= 1'b0;
        end else begin
            pc_o    <= pc_i;
            instr_o <= if_valid_i ? instr_i : '0;
            valid_o <= if_valid_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (hazard && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (flush_accept && (flush_cnt_o != '1))
                flush_cnt_o <= flush_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// tb/tb_if_id_stage.sv - directed self-checking bench for if_id_stage
module tb_if_id_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] pc_i;
    logic [31:0] instr_i;
    logic        if_valid_i;
    logic        flush_i;
    logic        idex_memread_i;
    logic [4:0]  idex_rd_i;

    logic [31:0] pc_o, instr_o;
    logic        valid_o, pc_write_o, stall_o, noop_o;
    logic [31:0] stall_cnt_o, flush_cnt_o;

    logic [31:0] n_pc_o, n_instr_o;
    logic        n_valid_o, n_pc_write_o, n_stall_o, n_noop_o;
    logic [1:0]  n_stall_cnt_o, n_flush_cnt_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk_i = ~clk_i;

    if_id_stage #(.XLEN(32), .PC_RESET(32'h0000_0000), .CNT_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .instr_i(instr_i),
        .if_valid_i(if_valid_i), .flush_i(flush_i),
        .idex_memread_i(idex_memread_i), .idex_rd_i(idex_rd_i),
        .pc_o(pc_o), .instr_o(instr_o), .valid_o(valid_o),
        .pc_write_o(pc_write_o), .stall_o(stall_o), .noop_o(noop_o),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    if_id_stage #(.XLEN(32), .PC_RESET(32'h0000_0000), .CNT_W(2)) dut_narrow (
        .clk_i(clk_i), .rst_i(rst_i), .pc_i(pc_i), .instr_i(instr_i),
        .if_valid_i(if_valid_i), .flush_i(flush_i),
        .idex_memread_i(idex_memread_i), .idex_rd_i(idex_rd_i),
        .pc_o(n_pc_o), .instr_o(n_instr_o), .valid_o(n_valid_o),
        .pc_write_o(n_pc_write_o), .stall_o(n_stall_o), .noop_o(n_noop_o),
        .stall_cnt_o(n_stall_cnt_o), .flush_cnt_o(n_flush_cnt_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b0; pc_i = 32'h44; instr_i = 32'h00A00093; if_valid_i = 1'b1;
        flush_i = 1'b0; idex_memread_i = 1'b0; idex_rd_i = 5'd0;
        tick();
        tick();
        check("rst_pc", pc_o, 32'h0);
        check("rst_instr", instr_o, 32'h0);
        check("rst_valid", {31'd0, valid_o}, 32'd0);
        check("rst_pc_write", {31'd0, pc_write_o}, 32'd1);
        check("rst_stall", {31'd0, stall_o}, 32'd0);
        check("rst_noop", {31'd0, noop_o}, 32'd0);
        check("rst_stall_cnt", stall_cnt_o, 32'd0);
        check("rst_flush_cnt", flush_cnt_o, 32'd0);

        // pass-through of addi x1,x0,10
        rst_i = 1'b1; pc_i = 32'h10; instr_i = 32'h00A00093;
        tick();
        check("pass_pc", pc_o, 32'h10);
        check("pass_instr", instr_o, 32'h00A00093);
        check("pass_valid", {31'd0, valid_o}, 32'd1);
        check("pass_stall", {31'd0, stall_o}, 32'd0);

        // addi does not use rs2 (field = 10); x0 load never stalls
        idex_memread_i = 1'b1; idex_rd_i = 5'd10; #1;
        check("nofalse_rs2", {31'd0, stall_o}, 32'd0);
        idex_rd_i = 5'd0; #1;
        check("nofalse_rd0", {31'd0, stall_o}, 32'd0);

        // load add x3,x1,x2
        idex_memread_i = 1'b0; pc_i = 32'h14; instr_i = 32'h002081B3;
        tick();
        check("add_instr", instr_o, 32'h002081B3);

        idex_memread_i = 1'b1; idex_rd_i = 5'd2; pc_i = 32'h18; instr_i = 32'h00000463; #1;
        check("lu_stall", {31'd0, stall_o}, 32'd1);
        check("lu_noop", {31'd0, noop_o}, 32'd1);
        check("lu_pc_write", {31'd0, pc_write_o}, 32'd0);
        tick();
        check("lu_hold_instr", instr_o, 32'h002081B3);
        check("lu_hold_pc", pc_o, 32'h14);
        check("lu_stall_cnt", stall_cnt_o, 32'd1);

        // flush while stalled is ignored
        flush_i = 1'b1; #1;
        check("fs_stall", {31'd0, stall_o}, 32'd1);
        tick();
        check("fs_hold_instr", instr_o, 32'h002081B3);
        check("fs_hold_pc", pc_o, 32'h14);
        check("fs_flush_cnt", flush_cnt_o, 32'd0);
        check("fs_stall_cnt", stall_cnt_o, 32'd2);

        // hazard clears, flush accepted
        idex_memread_i = 1'b0; #1;
        check("fl_pc_write", {31'd0, pc_write_o}, 32'd1);
        tick();
        check("fl_instr", instr_o, 32'h0);
        check("fl_valid", {31'd0, valid_o}, 32'd0);
        check("fl_pc", pc_o, 32'h18);
        check("fl_flush_cnt", flush_cnt_o, 32'd1);
        check("fl_stall_cnt", stall_cnt_o, 32'd2);

        // load resumes
        flush_i = 1'b0; pc_i = 32'h1C; instr_i = 32'h00A00093;
        tick();
        check("res_pc", pc_o, 32'h1C);
        check("res_instr", instr_o, 32'h00A00093);
        check("res_valid", {31'd0, valid_o}, 32'd1);

        // fetch bubble loads zero
        pc_i = 32'h20; instr_i = 32'hDEADBEEF; if_valid_i = 1'b0;
        tick();
        check("bub_instr", instr_o, 32'h0);
        check("bub_valid", {31'd0, valid_o}, 32'd0);
        check("bub_pc", pc_o, 32'h20);

        // rs1 hazard, then reset mid-stall
        if_valid_i = 1'b1; pc_i = 32'h24; instr_i = 32'h002081B3;
        tick();
        idex_memread_i = 1'b1; idex_rd_i = 5'd1; #1;
        check("rs1_stall", {31'd0, stall_o}, 32'd1);
        rst_i = 1'b0;
        tick();
        check("rstmid_instr", instr_o, 32'h0);
        check("rstmid_valid", {31'd0, valid_o}, 32'd0);
        check("rstmid_stall_cnt", stall_cnt_o, 32'd0);
        check("rstmid_flush_cnt", flush_cnt_o, 32'd0);
        check("rstmid_stall", {31'd0, stall_o}, 32'd0);

        // saturation: hold hazard 5 cycles
        rst_i = 1'b1; idex_memread_i = 1'b0;
        tick();
        check("sat_instr", instr_o, 32'h002081B3);
        idex_memread_i = 1'b1;
        tick(); tick(); tick();
        check("sat_narrow_3", {30'd0, n_stall_cnt_o}, 32'd3);
        tick(); tick();
        check("sat_wide_5", stall_cnt_o, 32'd5);
        check("sat_narrow_stuck", {30'd0, n_stall_cnt_o}, 32'd3);
        check("sat_narrow_flush", {30'd0, n_flush_cnt_o}, 32'd0);
        check("sat_narrow_hold", n_instr_o, 32'h002081B3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- IF/ID pipeline register for the 5-stage RV32 core.
- Captures the fetched PC and instruction, and drives the decode-stage consumers: the immediate generator, the register file read addresses and the control unit.
- Contains load-use hazard detection that stalls fetch and injects a bubble into ID/EX.
- Contains branch-flush handling and saturating stall/flush performance counters.

Parameters:
- XLEN, 32, width of PC and instruction.
- PC_RESET, 32'h0000_0000, value of pc_o after reset.
- CNT_W, 32, width of each performance counter.

Ports:
- clk_i  input  1  clock; all state updates on rising edge.
- rst_i  input  1  reset, synchronous, active-low.
- pc_i  input  XLEN  PC of the instruction being fetched.
- instr_i  input  XLEN  instruction word from instruction memory.
- if_valid_i  input  1  fetch output is a real instruction.
- flush_i  input  1  branch taken in ID; discard the instruction in fetch.
- idex_memread_i  input  1  instruction in EX is a load.
- idex_rd_i  input  5  destination register of the instruction in EX.
- pc_o  output  XLEN  registered PC to the ID stage.
- instr_o  output  XLEN  registered instruction to the decoder, immediate generator and register file.
- valid_o  output  1  instr_o holds a real instruction.
- pc_write_o  output  1  PC register update enable.
- stall_o  output  1  load-use hazard detected this cycle.
- noop_o  output  1  ID/EX must load zero control (bubble).
- stall_cnt_o  output  CNT_W  cycles stalled since reset.
- flush_cnt_o  output  CNT_W  flushes accepted since reset.

Behaviour:
- Reset (rst_i=0 at a rising edge):
  - pc_o=PC_RESET, instr_o=0, valid_o=0, both counters=0.
  - While valid_o=0, hazard=0, so pc_write_o=1, stall_o=0, noop_o=0.
  - Reset overrides all other inputs in the same cycle, including mid-stall or mid-flush.
- Source-use decode on the registered instr_o (opcode = instr_o[6:0]):
  - rs1 used for opcodes 0110011, 0010011, 0000011, 0100011, 1100011.
  - rs2 used for opcodes 0110011, 0100011, 1100011.
  - Any other opcode, including all-zero, uses neither.
- hazard (combinational, from registered state plus the current idex inputs) is 1 only when all of the following hold:
  - valid_o=1;
  - idex_memread_i=1;
  - idex_rd_i != 0;
  - (rs1 used and idex_rd_i == instr_o[19:15]) or (rs2 used and idex_rd_i == instr_o[24:20]).
- Combinational outputs: stall_o = hazard; noop_o = hazard; pc_write_o = ~hazard.
- Register update priority per rising edge, first match wins: reset > stall > flush > load.
  - Stall (hazard=1): pc_o, instr_o and valid_o hold. flush_i is ignored that cycle because the branch in ID lacks its operands; the controller re-asserts flush_i after the stall.
  - Flush (flush_i=1, hazard=0): instr_o<=0, valid_o<=0, pc_o<=pc_i.
  - Load: pc_o<=pc_i, valid_o<=if_valid_i, instr_o <= if_valid_i ? instr_i : 0.
- Latency: a fetched instruction appears on instr_o one cycle after it is presented, or more cycles when stalled.
- A load-use stall lasts exactly one cycle: the load advances to MEM, idex_memread_i drops next cycle and hazard clears.
- Counters:
  - stall_cnt_o increments by 1 on each rising edge where hazard=1.
  - flush_cnt_o increments by 1 on each edge where a flush is accepted (flush_i=1, hazard=0).
  - Both saturate at all-ones and never wrap.
  - Neither counter increments on an edge where rst_i=0.
- An all-zero instr_o must decode as a no-op downstream: the immediate generator yields 0 and there is no hazard.

Test Plan:
- Reset: hold rst_i=0 for 2 cycles with instr_i=32'h00A00093, if_valid_i=1 -> pc_o=0, instr_o=0, valid_o=0, pc_write_o=1, counters 0.
- Pass-through: pc_i=0x10, instr_i=0x00A00093 (addi x1,x0,10), if_valid_i=1 -> next cycle pc_o=0x10, instr_o=0x00A00093, valid_o=1, stall_o=0.
- Load-use stall:
  - instr_o=0x002081B3 (add x3,x1,x2), idex_memread_i=1, idex_rd_i=2 -> stall_o=1, noop_o=1, pc_write_o=0.
  - The next edge holds instr_o; stall_cnt_o=1.
  - With idex_memread_i=0 afterwards -> load resumes.
- No false hazard:
  - instr_o=0x00A00093 (addi, no rs2 use), idex_rd_i=10, memread=1 -> stall_o=0.
  - idex_rd_i=0 with a matching rs1 field -> stall_o=0.
- Flush: flush_i=1, hazard=0, instr_i=0x00000463 -> next cycle instr_o=0, valid_o=0, flush_cnt_o=1.
- Flush during stall: flush_i=1 and hazard=1 in the same cycle -> registers hold, flush_cnt_o unchanged. Then flush_i=1 with hazard=0 -> flush applied.
- Saturation: bench with CNT_W=2, hold hazard for 5 cycles -> stall_cnt_o sticks at 3.
